// File: rtl/axp_op_pipe.sv
// Operand-fetch / writeback stage wrapped around the opcode-10 integer adder.
// Reads the 32x64 register file with EX->OF forwarding, registers cmd/a/b for the adder, writes y back to Rc.
module axp_op_pipe #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic [31:0]      inst,
    input  logic             stall,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [4:0]       ld_reg,
    input  logic [63:0]      ld_data,
    output logic [31:0]      ex_cmd,
    output logic [63:0]      ex_a,
    output logic [63:0]      ex_b,
    input  logic [63:0]      ex_y,
    output logic             ex_valid,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam int         DATA_W  = 64;
    localparam logic [5:0] OP_INTA = 6'h10;
    localparam logic [4:0] R_ZERO  = 5'd31;

    logic [DATA_W-1:0] rf [0:31];

    logic              fire_p0;
    logic              legal_p0;
    logic [4:0]        ra_p0;
    logic [4:0]        rb_p0;
    logic              lit_sel_p0;
    logic [7:0]        lit_p0;
    logic              fwd_en_p0;
    logic [DATA_W-1:0] opa_p0;
    logic [DATA_W-1:0] opb_p0;

    logic [31:0]       cmd_p1;
    logic [DATA_W-1:0] a_p1;
    logic [DATA_W-1:0] b_p1;
    logic              vld_p1;
    logic              ill_p1;
    logic [CNT_W-1:0]  ret_p1;
    logic [4:0]        rc_p1;
    logic              wb_en_p1;
    logic              ld_en;

    // R31 reads as zero; otherwise the in-flight EX result overrides the file.
    function automatic logic [DATA_W-1:0] read_reg(
        input logic [4:0]        r,
        input logic              fwd_en,
        input logic [4:0]        fwd_rc,
        input logic [DATA_W-1:0] fwd_val,
        input logic [DATA_W-1:0] file_val
    );
        if (r == R_ZERO)
            return '0;
        if (fwd_en && (fwd_rc == r))
            return fwd_val;
        return file_val;
    endfunction

    // ---- p0: decode and operand fetch ----
    assign inst_ready = ~stall;
    assign fire_p0    = inst_valid & ~stall;
    assign legal_p0   = (inst[31:26] == OP_INTA);
    assign ra_p0      = inst[25:21];
    assign rb_p0      = inst[20:16];
    assign lit_p0     = inst[20:13];
    assign lit_sel_p0 = inst[12];

    assign rc_p1     = cmd_p1[4:0];
    assign fwd_en_p0 = vld_p1 & ~stall & (rc_p1 != R_ZERO);

    assign opa_p0 = read_reg(ra_p0, fwd_en_p0, rc_p1, ex_y, rf[ra_p0]);
    assign opb_p0 = lit_sel_p0 ? {{(DATA_W-8){1'b0}}, lit_p0}
                               : read_reg(rb_p0, fwd_en_p0, rc_p1, ex_y, rf[rb_p0]);

    // ---- p1: EX register feeding the adder ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_p1 <= '0;
            a_p1   <= '0;
            b_p1   <= '0;
            vld_p1 <= 1'b0;
            ill_p1 <= 1'b0;
            ret_p1 <= '0;
        end else begin
            ill_p1 <= fire_p0 & ~legal_p0;
            if (!stall) begin
                vld_p1 <= fire_p0 & legal_p0;
                if (fire_p0 && legal_p0) begin
                    cmd_p1 <= inst;
                    a_p1   <= opa_p0;
                    b_p1   <= opb_p0;
                end
            end
            if (wb_en_p1)
                ret_p1 <= ret_p1 + CNT_W'(1);
        end
    end

    // ---- p2: writeback and preload into the register file ----
    assign wb_en_p1 = vld_p1 & ~stall;
    assign ld_ready = ~vld_p1;
    assign ld_en    = ld_valid & ld_ready & (ld_reg != R_ZERO);

    // Preload is only accepted with EX empty, so the two write sources never coincide.
    always_ff @(posedge clock) begin
        if (wb_en_p1 && (rc_p1 != R_ZERO))
            rf[rc_p1] <= ex_y;
        else if (ld_en)
            rf[ld_reg] <= ld_data;
    end

    assign ex_cmd   = cmd_p1;
    assign ex_a     = a_p1;
    assign ex_b     = b_p1;
    assign ex_valid = vld_p1;
    assign illegal  = ill_p1;
    assign retired  = ret_p1;

endmodule
